// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake: request and address toward memory,
// ready back from memory.
interface pc_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic             imem_ready;
    logic [WIDTH-1:0] pc;

    modport master (
        output imem_req,
        output pc,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  pc,
        output imem_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch request sequencer. Selects the next PC from
// sequential, branch and jump sources and squashes wrong-path fetches.
//
// state | meaning
// IDLE  | no request outstanding; pc may be redirected here
// REQ   | request outstanding at pc; pc frozen until imem_ready
module pc_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_pc4,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    pc_fetch_unit_if.master  imem,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pc_q, pc_next;
    logic             pend_valid, pend_valid_next;
    logic [WIDTH-1:0] pend_target, pend_target_next;
    logic             imem_req_c;

    logic             redirect;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] redir_target;

    assign branch_target = branch_pc4 + branch_offset;
    assign redirect      = jump | branch_taken;
    assign redir_target  = jump ? jump_target : branch_target;
    assign pc_plus4      = pc_q + WIDTH'(4);

    assign imem.pc       = pc_q;
    assign imem.imem_req = imem_req_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc_q        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pc_q        <= pc_next;
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc_q;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
        imem_req_c       = 1'b0;
        fetch_valid      = 1'b0;

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next = redir_target;
                end else if (pend_valid) begin
                    pc_next         = pend_target;
                    pend_valid_next = 1'b0;
                end
                if (!stall) state_next = REQ;
            end

            REQ: begin
                imem_req_c = 1'b1;
                if (imem.imem_ready) begin
                    // A redirect seen now or during the wait makes this fetch wrong-path.
                    fetch_valid     = ~(redirect | pend_valid);
                    pend_valid_next = 1'b0;
                    if (redirect)        pc_next = redir_target;
                    else if (pend_valid) pc_next = pend_target;
                    else                 pc_next = pc_plus4;
                    state_next = stall ? IDLE : REQ;
                end else if (redirect) begin
                    pend_valid_next  = 1'b1;
                    pend_target_next = redir_target;
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: free run, wait states, redirects,
// stall, reset mid-wait and PC wrap.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset1;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc4;
    logic [31:0] branch_offset;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_plus4, pc_plus4_1;
    logic        fetch_valid, fetch_valid_1;

    int vectors = 0;
    int errors  = 0;

    pc_fetch_unit_if #(.WIDTH(32)) if0 ();
    pc_fetch_unit_if #(.WIDTH(32)) if1 ();

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_pc4    (branch_pc4),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem          (if0.master),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid)
    );

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .reset         (reset1),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_pc4    (branch_pc4),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem          (if1.master),
        .pc_plus4      (pc_plus4_1),
        .fetch_valid   (fetch_valid_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Settle after driving inputs at the falling edge, then check the main DUT.
    task automatic look(input string tag, input logic req, input logic [31:0] pcv, input logic fv);
        #1;
        chk({tag, ".req"}, {31'b0, if0.imem_req}, {31'b0, req});
        chk({tag, ".pc"},  if0.pc, pcv);
        chk({tag, ".fv"},  {31'b0, fetch_valid}, {31'b0, fv});
    endtask

    task automatic look1(input string tag, input logic req, input logic [31:0] pcv, input logic fv);
        #1;
        chk({tag, ".req"}, {31'b0, if1.imem_req}, {31'b0, req});
        chk({tag, ".pc"},  if1.pc, pcv);
        chk({tag, ".fv"},  {31'b0, fetch_valid_1}, {31'b0, fv});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic br(input logic [31:0] p4, input logic [31:0] off);
        branch_taken  = 1'b1;
        branch_pc4    = p4;
        branch_offset = off;
    endtask

    task automatic no_redir();
        branch_taken  = 1'b0;
        jump          = 1'b0;
        branch_pc4    = '0;
        branch_offset = '0;
        jump_target   = '0;
    endtask

    initial begin
        reset  = 1'b1;
        reset1 = 1'b1;
        stall  = 1'b0;
        no_redir();
        if0.imem_ready = 1'b1;
        if1.imem_ready = 1'b1;

        // reset
        nxt(); look("rst0", 1'b0, 32'h0, 1'b0);
        nxt(); reset = 1'b0;
        look("idle", 1'b0, 32'h0, 1'b0);

        // free run and wait states at 0x4 (stall ignored while waiting)
        nxt(); look("run0", 1'b1, 32'h0, 1'b1);
        chk("pc4_0", pc_plus4, 32'h4);
        nxt(); if0.imem_ready = 1'b0; look("wait1", 1'b1, 32'h4, 1'b0);
        nxt(); stall = 1'b1;          look("wait2", 1'b1, 32'h4, 1'b0);
        nxt(); stall = 1'b0;          look("wait3", 1'b1, 32'h4, 1'b0);
        nxt(); if0.imem_ready = 1'b1; look("ready4", 1'b1, 32'h4, 1'b1);

        // branch on completion: 0x8 + 0x10 = 0x18
        nxt(); br(32'h8, 32'h10); look("brc", 1'b1, 32'h8, 1'b0);
        nxt(); no_redir();        look("brc_tgt", 1'b1, 32'h18, 1'b1);
        chk("pc4_18", pc_plus4, 32'h1C);

        // jump has priority over simultaneous branch
        nxt(); br(32'h100, 32'h4); jump = 1'b1; jump_target = 32'h400;
        look("jmp", 1'b1, 32'h1C, 1'b0);
        nxt(); no_redir(); look("jmp_tgt", 1'b1, 32'h400, 1'b1);

        // branch during wait, negative offset: 0x28 - 0x10 = 0x18
        nxt(); if0.imem_ready = 1'b0; br(32'h28, 32'hFFFF_FFF0);
        look("bw_hit", 1'b1, 32'h404, 1'b0);
        nxt(); no_redir();            look("bw_hold", 1'b1, 32'h404, 1'b0);
        nxt(); if0.imem_ready = 1'b1; look("bw_sq", 1'b1, 32'h404, 1'b0);
        nxt();                        look("bw_tgt", 1'b1, 32'h18, 1'b1);

        // two redirects in one wait: newest (jump 0x40) wins over branch 0x30
        nxt(); if0.imem_ready = 1'b0; br(32'h20, 32'h10);
        look("nw1", 1'b1, 32'h1C, 1'b0);
        nxt(); no_redir(); jump = 1'b1; jump_target = 32'h40;
        look("nw2", 1'b1, 32'h1C, 1'b0);
        nxt(); no_redir(); if0.imem_ready = 1'b1;
        look("nw_sq", 1'b1, 32'h1C, 1'b0);
        nxt(); look("nw_tgt", 1'b1, 32'h40, 1'b1);

        // stall on completion drops to IDLE at pc+4
        stall = 1'b1; #0;
        chk("st_fv", {31'b0, fetch_valid}, 32'h1);
        nxt(); look("st_idle1", 1'b0, 32'h44, 1'b0);
        nxt(); look("st_idle2", 1'b0, 32'h44, 1'b0);
        nxt(); stall = 1'b0; look("st_rel", 1'b0, 32'h44, 1'b0);
        nxt(); look("st_req", 1'b1, 32'h44, 1'b1);

        // redirect while idle: 0x50 + 0x30 = 0x80
        stall = 1'b1;
        nxt(); br(32'h50, 32'h30); look("ir_idle", 1'b0, 32'h48, 1'b0);
        nxt(); no_redir(); stall = 1'b0; look("ir_moved", 1'b0, 32'h80, 1'b0);
        nxt(); look("ir_req", 1'b1, 32'h80, 1'b1);

        // reset mid-wait abandons request and pending redirect to 0x200
        nxt(); if0.imem_ready = 1'b0; br(32'h100, 32'h100);
        look("rw_pend", 1'b1, 32'h84, 1'b0);
        nxt(); no_redir(); reset = 1'b1;
        nxt(); reset = 1'b0; if0.imem_ready = 1'b1;
        look("rw_rst", 1'b0, 32'h0, 1'b0);
        nxt(); look("rw_req", 1'b1, 32'h0, 1'b1);
        nxt(); look("rw_seq", 1'b1, 32'h4, 1'b1);

        // wrap from 0xFFFFFFFC
        reset1 = 1'b0;
        look1("wr_idle", 1'b0, 32'hFFFF_FFFC, 1'b0);
        chk("wr_pc4", pc_plus4_1, 32'h0);
        nxt(); look1("wr_top", 1'b1, 32'hFFFF_FFFC, 1'b1);
        nxt(); look1("wr_zero", 1'b1, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch request sequencer for the MIPS datapath.
- Sits downstream of the shift-left-by-2 stage: it consumes the word-aligned branch offset and forms the branch target.
- Selects the next PC (sequential, branch, jump) and issues a request/ready fetch to instruction memory.
- Reports completed fetches and squashes fetches that lie on the wrong path.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  downstream cannot accept a new instruction; blocks issue of the next request.
- branch_taken  input  1  decode resolved a taken branch this cycle.
- branch_pc4  input  WIDTH  PC+4 of the branch instruction.
- branch_offset  input  WIDTH  sign-extended immediate, already shifted left by 2.
- jump  input  1  decode resolved a jump this cycle.
- jump_target  input  WIDTH  fully formed jump address.
- imem_ready  input  1  instruction memory completes the outstanding request this cycle.
- imem_req  output  1  fetch request, address = pc.
- pc  output  WIDTH  current fetch address (registered).
- pc_plus4  output  WIDTH  pc + 4, combinational, modulo 2^WIDTH.
- fetch_valid  output  1  one-cycle pulse: the fetch at pc completed and is on the correct path.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, fetch_valid=0, pend_valid=0, pend_target=0. Reset overrides all other inputs; a request outstanding at reset is abandoned.
- Arithmetic: branch_target = branch_pc4 + branch_offset, truncated to WIDTH (wraps). pc_plus4 also wraps; e.g. 0xFFFFFFFC -> 0x00000000.
- Redirect selection: redirect = jump | branch_taken. redir_target = jump ? jump_target : branch_target. Jump has priority over branch.
- States:
  - IDLE: imem_req=0. pc may change here.
    - If redirect: pc <= redir_target.
    - Else if pend_valid: pc <= pend_target and pend_valid <= 0.
    - Next state: REQ if stall=0, else stay in IDLE.
  - REQ: imem_req=1. pc is held stable until imem_ready=1 (address-stability rule).
    - imem_ready=0 and redirect: pend_valid <= 1 and pend_target <= redir_target. A later redirect overwrites the pending one (newest wins). pc is unchanged.
    - imem_ready=1: fetch_valid = ~(redirect | pend_valid), i.e. a fetch completing with a redirect present or pending is squashed.
    - imem_ready=1, next pc: redirect ? redir_target : pend_valid ? pend_target : pc_plus4. pend_valid <= 0.
    - imem_ready=1, next state: REQ if stall=0 (back-to-back fetch, 1 instruction/cycle when ready is held high), else IDLE.
- Fetch latency: request issued in cycle N, completion reported in the cycle imem_ready=1 (minimum same cycle). No instruction data passes through this block.
- fetch_valid is combinational from state/imem_ready/redirect/pend_valid and is 0 outside REQ.
- stall is ignored in REQ while imem_ready=0: a request already issued is never withdrawn.

Test Plan:
1. Free run: reset high 2 cycles, then low with imem_ready=1, stall=0 -> IDLE 1 cycle; then imem_req=1 and pc=0x0,0x4,0x8,0xC on consecutive cycles, fetch_valid=1 each cycle.
2. Wait states: at pc=0x4 hold imem_ready=0 for 3 cycles -> pc stays 0x4 and imem_req=1 throughout; fetch_valid=1 only in the ready cycle; next pc=0x8.
3. Branch on completion: pc=0x8, imem_ready=1, branch_taken=1, branch_pc4=0x8, branch_offset=0x10 -> fetch_valid=0 that cycle, next pc=0x18. Then jump=1 with branch_taken=1, jump_target=0x400 in a ready cycle -> next pc=0x400.
4. Branch during wait: imem_ready=0, branch_taken pulse with target 0x18, pc=0xC -> pc stays 0xC; when ready rises, fetch_valid=0 and next pc=0x18. A second redirect to 0x40 during the same wait -> next pc=0x40.
5. Stall: ready cycle at pc=0x10 with stall=1 -> fetch_valid=1, pc becomes 0x14, imem_req=0 while stall stays high; stall drops -> imem_req=1 the next cycle at 0x14. A redirect to 0x80 while in IDLE -> pc=0x80 before the request.
6. Wrap/reset: RESET_PC=0xFFFFFFFC -> fetch 0xFFFFFFFC then 0x00000000. Assert reset mid-wait -> next cycle pc=RESET_PC, imem_req=0, pending redirect cleared.
